// File: rtl/tlu_stream_arbiter.sv
// rtl/tlu_stream_arbiter.sv - round-robin burst arbiter merging FWFT sources into one FWFT output
module tlu_stream_arbiter #(
    parameter int         N_SRC        = 4,
    parameter int         MAX_BURST    = 16,
    parameter bit         HEADER_EN    = 1'b1,
    parameter logic [7:0] HEADER_MAGIC = 8'hA5
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic [N_SRC-1:0]     ENABLE,
    input  logic [N_SRC-1:0]     SRC_FIFO_EMPTY,
    input  logic [16*N_SRC-1:0]  SRC_FIFO_DATA,
    output logic [N_SRC-1:0]     SRC_FIFO_READ,
    input  logic                 FIFO_READ,
    output logic                 FIFO_EMPTY,
    output logic [15:0]          FIFO_DATA,
    output logic [N_SRC-1:0]     GRANT
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [N_SRC-1:0] grant_n;
    logic [1:0]       gidx, gidx_n;
    logic [1:0]       ptr, ptr_n;
    logic [CW-1:0]    count, count_n;
    logic             out_valid, out_valid_n;
    logic [15:0]      out_data, out_data_n;

    logic             load_ok;
    logic [3:0]       elig4;
    logic [3:0]       empty4;
    logic [3:0]       enable4;
    logic [63:0]      data64;
    logic             pick_found;
    logic [1:0]       pick_idx;
    logic [1:0]       cand;
    logic             sel_empty;
    logic             sel_enable;
    logic [15:0]      sel_data;
    logic [1:0]       next_ptr;
    logic             pop;
    logic             burst_end;

    // Sources are padded to four lanes so the 2-bit owner index selects them directly.
    assign empty4   = 4'(SRC_FIFO_EMPTY);
    assign enable4  = 4'(ENABLE);
    assign data64   = 64'(SRC_FIFO_DATA);
    assign elig4    = enable4 & ~empty4;
    assign load_ok  = !out_valid || FIFO_READ;
    assign next_ptr = (int'(gidx) == N_SRC - 1) ? 2'd0 : gidx + 2'd1;

    assign sel_empty  = empty4[gidx];
    assign sel_enable = enable4[gidx];
    assign sel_data   = data64[{gidx, 4'b0000} +: 16];

    assign FIFO_EMPTY = !out_valid;
    assign FIFO_DATA  = out_data;

    // Round-robin search: first eligible source at or after ptr, wrapping modulo N_SRC.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = 2'((int'(ptr) + k) % N_SRC);
            if (!pick_found && elig4[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state, output stage and pop strobe; every register holds unless a branch moves it.
    always_comb begin
        state_n       = state;
        grant_n       = GRANT;
        gidx_n        = gidx;
        ptr_n         = ptr;
        count_n       = count;
        out_valid_n   = out_valid;
        out_data_n    = out_data;
        SRC_FIFO_READ = '0;
        pop           = 1'b0;
        burst_end     = 1'b0;

        // A sink read empties the output register unless a load below refills it.
        if (FIFO_READ) begin
            out_valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                // Decisions wait while a stalled word still sits in the output register.
                if (pick_found && load_ok) begin
                    state_n = HEADER_EN ? HDR : BURST;
                    grant_n = N_SRC'(1) << pick_idx;
                    gidx_n  = pick_idx;
                    count_n = '0;
                end
            end
            HDR: begin
                if (load_ok) begin
                    out_valid_n = 1'b1;
                    out_data_n  = {HEADER_MAGIC, 6'b000000, gidx};
                    state_n     = BURST;
                end
            end
            BURST: begin
                pop = load_ok && !sel_empty;
                if (pop) begin
                    SRC_FIFO_READ = GRANT;
                    out_valid_n   = 1'b1;
                    out_data_n    = sel_data;
                    count_n       = count + 1'b1;
                end
                // A dropped enable still lets the word loaded this cycle through.
                burst_end = (pop && count == CW'(MAX_BURST - 1)) ||
                            (load_ok && count != '0 && (sel_empty || !sel_enable));
                if (burst_end) begin
                    state_n = IDLE;
                    grant_n = '0;
                    ptr_n   = next_ptr;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    // State and output registers; reset discards any word in flight.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state     <= IDLE;
            GRANT     <= '0;
            gidx      <= 2'd0;
            ptr       <= 2'd0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= 16'h0000;
        end else begin
            state     <= state_n;
            GRANT     <= grant_n;
            gidx      <= gidx_n;
            ptr       <= ptr_n;
            count     <= count_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
        end
    end

endmodule
